// File: rtl/spram_fifo_pkg.sv
// Shared constants and types for the single-port-RAM byte FIFO controller.
package spram_fifo_pkg;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {StEmpty, StPend, StHold} out_state_e;

  typedef enum logic {GntWr, GntRd} grant_e;

endpackage

// File: rtl/spram_fifo_arb.sv
// Two-request round-robin arbiter for the RAM access slot; a tie goes to the side
// that did not win last time.
module spram_fifo_arb
  import spram_fifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_req,
  input  logic   rd_req,
  output logic   gnt_wr,
  output logic   gnt_rd,
  output grant_e last_grant
);

  grant_e last_grant_d, last_grant_q;

  always_comb begin
    gnt_wr       = wr_req & (~rd_req | (last_grant_q == GntRd));
    gnt_rd       = rd_req & (~wr_req | (last_grant_q == GntWr));
    last_grant_d = last_grant_q;
    if (gnt_wr) begin
      last_grant_d = GntWr;
    end else if (gnt_rd) begin
      last_grant_d = GntRd;
    end
  end

  // Reset to read-last so the first tie favours the write side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GntRd;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/spram_fifo_ctrl.sv
// 128-entry byte FIFO built on a 128 x 8 single-port RAM with valid/ready on both sides.
// Define SPRAM_FIFO_STATUS_EN to add the registered level and almost_full outputs.
module spram_fifo_ctrl
  import spram_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
`ifdef SPRAM_FIFO_STATUS_EN
  ,
  output logic [AW:0]   level,
  output logic          almost_full
`endif
);

  localparam logic [AW:0]   CntFull       = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntAlmostFull = (AW + 1)'(DEPTH - 4);
  localparam logic [AW:0]   CntOne        = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne        = AW'(1);

  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [AW:0]   count_d, count_q;
  out_state_e    state_d, state_q;
  logic [DW-1:0] out_data_d, out_data_q;
  logic          not_full, wr_req, rd_req, gnt_wr, gnt_rd;
  grant_e        last_grant;

  assign not_full = (count_q != CntFull);
  assign wr_req   = in_valid & not_full;
  assign rd_req   = (count_q != '0) & (state_q == StEmpty);
  // Derived without in_valid: a pending read that is owed the slot blocks the push.
  assign in_ready = not_full & ~(rd_req & (last_grant == GntWr));

  spram_fifo_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .gnt_wr     (gnt_wr),
    .gnt_rd     (gnt_rd),
    .last_grant (last_grant)
  );

  always_comb begin
    ram_a    = rd_ptr_q;
    ram_d    = '0;
    ram_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (gnt_wr) begin
      ram_a    = wr_ptr_q;
      ram_d    = in_data;
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PtrOne;
      count_d  = count_q + CntOne;
    end else if (gnt_rd) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      count_d  = count_q - CntOne;
    end
  end

  // RAM read data lands one cycle after the grant, i.e. while in StPend.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StEmpty: if (gnt_rd) state_d = StPend;
      StPend: begin
        state_d    = StHold;
        out_data_d = ram_q;
      end
      StHold:  if (out_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StEmpty;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (state_q == StHold);

`ifdef SPRAM_FIFO_STATUS_EN
  logic [AW:0] level_q;
  logic        almost_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= count_d;
      almost_full_q <= (count_d >= CntAlmostFull);
    end
  end

  assign level       = level_q;
  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: behavioural RAM, queue scoreboard, directed and random traffic.
module tb_spram_fifo_ctrl;
  import spram_fifo_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q = '0;
`ifdef SPRAM_FIFO_STATUS_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_pop = '0;
  logic [DW-1:0] exp_word;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int pop_cnt = 0;
  int exp_lvl;
  int last_pop_cyc;
  bit got;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  spram_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ram_a       (ram_a),
    .ram_d       (ram_d),
    .ram_we      (ram_we),
    .ram_q       (ram_q)
`ifdef SPRAM_FIFO_STATUS_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: scores this cycle's handshakes, then advances to posedge+1.
  task automatic step();
    if (in_valid && in_ready) begin
      check("push_ram_we", 32'(ram_we), 32'd1);
      check("push_ram_a", 32'(ram_a), 32'(wr_cnt % DEPTH));
      check("push_ram_d", 32'(ram_d), 32'(in_data));
      exp_q.push_back(in_data);
      wr_cnt++;
    end else begin
      check("idle_ram_we", 32'(ram_we), 32'd0);
    end
    if (out_valid && out_ready) begin
      check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("pop_data", 32'(out_data), 32'(exp_word));
      end
      last_pop = out_data;
      pop_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
`ifdef SPRAM_FIFO_STATUS_EN
    check("rst_level", 32'(level), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
`endif
    exp_q.delete();
    wr_cnt  = 0;
    pop_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    @(negedge clk);
    check({tag, "_drain_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ov_pat;
    logic [2:0] ir_pat;
    ov_pat = 8'b0100_1000;
    ir_pat = 3'b101;
    #3;
    do_reset();

    // First-word latency: AA accepted at k=0, read owns k=1, BB waits until k=2.
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lat_out_valid", 32'(out_valid), 32'(ov_pat[k]));
      if (k < 3) check("lat_in_ready", 32'(in_ready), 32'(ir_pat[k]));
      if (k == 3) check("lat_data_aa", 32'(out_data), 32'h0000_00AA);
      if (k == 6) check("lat_data_bb", 32'(out_data), 32'h0000_00BB);
      step();
      if (k == 0) in_data = 8'hBB;
      if (k == 2) in_valid = 1'b0;
    end
    drain("lat");

    // Fill with the output stalled: one word sits in the output register, 128 in RAM.
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 8'h00;
    for (int k = 0; k < 134; k++) begin
      exp_lvl = (k < 2) ? k : ((k - 2 > 128) ? 128 : k - 2);
      @(negedge clk);
      check("fill_in_ready", 32'(in_ready), 32'(k != 1 && k < 130));
      check("fill_out_valid", 32'(out_valid), 32'(k >= 3));
`ifdef SPRAM_FIFO_STATUS_EN
      check("fill_level", 32'(level), 32'(exp_lvl));
      check("fill_almost_full", 32'(almost_full), 32'(exp_lvl >= 124));
`endif
      step();
      in_data = 8'(wr_cnt);
    end
    check("fill_total", 32'(wr_cnt), 32'(DEPTH + 1));

    // Pop one from full, then 5C must be accepted and come out last.
    out_ready = 1'b1;
    in_data   = 8'h5C;
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) got = 1'b1;
      step();
      if (got) in_valid = 1'b0;
    end
    check("refill_accept", 32'(got), 32'd1);
    drain("wrap");
    check("wrap_last_5c", 32'(last_pop), 32'h0000_005C);
    check("wrap_pop_count", 32'(pop_cnt), 32'd130);

    // Continuous traffic: once primed, pops come every third cycle.
    do_reset();
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    last_pop_cyc = -1;
    for (int i = 0; i < 6000 && wr_cnt < 1000; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (out_valid) begin
        if (last_pop_cyc >= 0) check("pop_interval", 32'(i - last_pop_cyc), 32'd3);
        last_pop_cyc = i;
      end
      step();
    end
    check("stream_pushed", 32'(wr_cnt), 32'd1000);
    drain("stream");
    check("stream_popped", 32'(pop_cnt), 32'd1000);

    // Random valid/ready on both sides.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      @(negedge clk);
      step();
    end
    drain("rand");
    check("rand_balance", 32'(pop_cnt), 32'(wr_cnt));

    // Reset while a read is in flight (output FSM pending, five words in RAM).
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 8'h30;
    for (int i = 0; i < 20 && wr_cnt < 6; i++) begin
      @(negedge clk);
      step();
      in_data = 8'h30 + 8'(wr_cnt);
    end
    out_ready = 1'b1;
    in_data   = 8'h36;
    @(negedge clk);
    check("mid_hold_valid", 32'(out_valid), 32'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_empty_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
`ifdef SPRAM_FIFO_STATUS_EN
    check("mid_level", 32'(level), 32'd5);
`endif
    do_reset();
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'(k == 3));
      if (k == 3) check("post_rst_data", 32'(out_data), 32'h0000_0011);
      step();
      if (k == 0) in_valid = 1'b0;
    end
    drain("post_rst");
    check("post_rst_pops", 32'(pop_cnt), 32'd1);
    check("post_rst_last", 32'(last_pop), 32'h0000_0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
